// File: rtl/tdm_pkg.sv
// tdm_pkg: shared framer state, channel count and slot index width for the TDM demux.
package tdm_pkg;
   typedef enum logic {HUNT, LOCKED} state_e;
   localparam int NUM_CH = 4;
   localparam int SLOT_W = 2;
endpackage

// File: rtl/tdm_bit_counter.sv
// tdm_bit_counter: bit-within-slot and slot-within-frame position counter.
module tdm_bit_counter
   import tdm_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   output logic [SLOT_W-1:0] slot_cnt,
   output logic              frame_last,
   output logic              at_start
);
   localparam int BW = $clog2(DATA_W);
   logic [BW-1:0] bit_q, bit_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic bit_last;
   assign bit_last = bit_q == BW'(DATA_W - 1);
   assign frame_last = bit_last && slot_q == SLOT_W'(NUM_CH - 1);
   assign at_start = bit_q == '0 && slot_q == '0;
   assign slot_cnt = slot_q;
   // clr with en means the current bit is taken as position 0, so resume at bit 1
   always_comb begin
      bit_d = bit_q;
      slot_d = slot_q;
      if (clr) begin
         bit_d = en ? BW'(1) : '0;
         slot_d = '0;
      end else if (en) begin
         bit_d = bit_last ? '0 : bit_q + 1'b1;
         slot_d = bit_last ? slot_q + 1'b1 : slot_q;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_q <= '0;
         slot_q <= '0;
      end else begin
         bit_q <= bit_d;
         slot_q <= slot_d;
      end
   end
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: 4-channel serial TDM framer; hunts for fsync, shifts slots into shadows,
// publishes whole frames atomically and flags framing violations.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ser_in,
   input  logic              ser_vld,
   input  logic              fsync,
   output logic [DATA_W-1:0] ch0,
   output logic [DATA_W-1:0] ch1,
   output logic [DATA_W-1:0] ch2,
   output logic [DATA_W-1:0] ch3,
   output logic              frame_vld,
   output logic              locked,
   output logic              sync_err
);
   state_e state_q, state_d;
   logic [DATA_W-1:0] sh_q [NUM_CH];
   logic [DATA_W-1:0] sh_d [NUM_CH];
   logic [DATA_W-1:0] ch_q [NUM_CH];
   logic [DATA_W-1:0] ch_d [NUM_CH];
   logic frame_vld_q, frame_vld_d, locked_q, locked_d, sync_err_q, sync_err_d;
   logic [SLOT_W-1:0] slot;
   logic frame_last, at_start, hunt_start, lost, resync, cnt_en, cnt_clr, publish;
   assign hunt_start = ser_vld && state_q == HUNT && fsync;
   assign lost = ser_vld && state_q == LOCKED && at_start && !fsync;
   assign resync = ser_vld && state_q == LOCKED && !at_start && fsync;
   assign cnt_en = hunt_start || (ser_vld && state_q == LOCKED && !lost);
   assign cnt_clr = hunt_start || resync || lost;
   assign publish = cnt_en && !cnt_clr && frame_last;
   tdm_bit_counter #(.DATA_W(DATA_W)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (cnt_en),
      .clr        (cnt_clr),
      .slot_cnt   (slot),
      .frame_last (frame_last),
      .at_start   (at_start)
   );
   // a fresh slot-0 MSB overwrites shadow 0; stale bits in other slots shift out before use
   always_comb begin
      state_d = lost ? HUNT : (hunt_start ? LOCKED : state_q);
      sh_d = sh_q;
      ch_d = ch_q;
      if (hunt_start || resync)
         sh_d[0] = DATA_W'(ser_in);
      else if (cnt_en)
         sh_d[slot] = {sh_q[slot][DATA_W-2:0], ser_in};
      if (publish)
         ch_d = sh_d;
      frame_vld_d = publish;
      sync_err_d = lost || resync;
      locked_d = state_d == LOCKED;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         sh_q <= '{default: '0};
         ch_q <= '{default: '0};
         frame_vld_q <= 1'b0;
         locked_q <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q <= sh_d;
         ch_q <= ch_d;
         frame_vld_q <= frame_vld_d;
         locked_q <= locked_d;
         sync_err_q <= sync_err_d;
      end
   end
   assign ch0 = ch_q[0];
   assign ch1 = ch_q[1];
   assign ch2 = ch_q[2];
   assign ch3 = ch_q[3];
   assign frame_vld = frame_vld_q;
   assign locked = locked_q;
   assign sync_err = sync_err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed and randomized frames checked against a bit-queue framing model.
module tb_tdm_demux;
   localparam int DW = 8;
   localparam int FB = 4 * DW;
   logic clk = 1'b0;
   logic rst_n, ser_in, ser_vld, fsync;
   logic [DW-1:0] ch0, ch1, ch2, ch3;
   logic frame_vld, locked, sync_err;
   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int fv_cnt = 0;
   int fv_last = 0;
   int fv_gap = 0;
   int se_cnt = 0;
   bit m_lock;
   bit m_fv, m_se;
   bit q[$];
   logic [DW-1:0] m_ch [4];
   tdm_demux #(.DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ser_in    (ser_in),
      .ser_vld   (ser_vld),
      .fsync     (fsync),
      .ch0       (ch0),
      .ch1       (ch1),
      .ch2       (ch2),
      .ch3       (ch3),
      .frame_vld (frame_vld),
      .locked    (locked),
      .sync_err  (sync_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
      end
   endtask
   task automatic cmp_all();
      chk("ch0", 32'(ch0), 32'(m_ch[0]));
      chk("ch1", 32'(ch1), 32'(m_ch[1]));
      chk("ch2", 32'(ch2), 32'(m_ch[2]));
      chk("ch3", 32'(ch3), 32'(m_ch[3]));
      chk("frame_vld", 32'(frame_vld), 32'(m_fv));
      chk("sync_err", 32'(sync_err), 32'(m_se));
      chk("locked", 32'(locked), 32'(m_lock));
   endtask
   // framing rules on a queue of received bits: empty queue while locked = frame boundary
   task automatic model_bit(input bit b, input bit f);
      if (!m_lock) begin
         if (f) begin
            m_lock = 1'b1;
            q = {b};
         end
      end else if (q.size() == 0) begin
         if (f) q.push_back(b);
         else begin
            m_se = 1'b1;
            m_lock = 1'b0;
         end
      end else if (f) begin
         m_se = 1'b1;
         q = {b};
      end else begin
         q.push_back(b);
         if (q.size() == FB) begin
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < DW; j++)
                  m_ch[i][DW-1-j] = q[i*DW+j];
            m_fv = 1'b1;
            q.delete();
         end
      end
   endtask
   task automatic step(input bit v, input bit b, input bit f);
      @(negedge clk);
      ser_vld = v;
      ser_in = b;
      fsync = f;
      @(posedge clk);
      cyc++;
      m_fv = 1'b0;
      m_se = 1'b0;
      if (v) model_bit(b, f);
      #1;
      cmp_all();
      if (frame_vld) begin
         fv_gap = cyc - fv_last;
         fv_last = cyc;
         fv_cnt++;
      end
      if (sync_err) se_cnt++;
   endtask
   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      m_lock = 1'b0;
      m_fv = 1'b0;
      m_se = 1'b0;
      q.delete();
      m_ch = '{default: '0};
      cmp_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   // gap: 0 none, 1 alternate invalid cycles, 2 random invalid cycles
   task automatic send_frame(input logic [31:0] w, input bit fs, input int gap, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         if (gap == 1 && i > 0) step(1'b0, 1'($urandom), 1'($urandom));
         if (gap == 2) repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom), 1'($urandom));
         step(1'b1, w[31-i], fs && i == 0);
      end
   endtask
   initial begin
      int c0, s0;
      logic [31:0] w;
      rst_n = 1'b0;
      ser_in = 1'b0;
      ser_vld = 1'b0;
      fsync = 1'b0;
      m_ch = '{default: '0};
      m_lock = 1'b0;
      m_fv = 1'b0;
      m_se = 1'b0;
      repeat (2) @(negedge clk);
      cmp_all();
      rst_n = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      chk("hunt_ignores", 32'(locked), 32'd0);
      send_frame(32'hA53CFF00, 1'b1, 0, FB);
      chk("f1_vld", 32'(frame_vld), 32'd1);
      chk("f1_ch", {ch0, ch1, ch2, ch3}, 32'hA53CFF00);
      chk("f1_locked", 32'(locked), 32'd1);
      c0 = fv_cnt;
      s0 = se_cnt;
      send_frame(32'h01020480, 1'b1, 0, FB);
      chk("b2b_spacing", 32'(fv_gap), 32'(FB));
      chk("b2b_ch", {ch0, ch1, ch2, ch3}, 32'h01020480);
      pulse_reset();
      c0 = cyc;
      send_frame(32'hA53CFF00, 1'b1, 1, FB);
      chk("gap_latency", 32'(fv_last - c0), 32'(2 * FB - 1));
      chk("gap_ch", {ch0, ch1, ch2, ch3}, 32'hA53CFF00);
      s0 = se_cnt;
      send_frame(32'h12345678, 1'b0, 0, FB);
      chk("miss_err", 32'(se_cnt - s0), 32'd1);
      chk("miss_unlock", 32'(locked), 32'd0);
      chk("miss_keep", {ch0, ch1, ch2, ch3}, 32'hA53CFF00);
      send_frame(32'hDEADBEEF, 1'b1, 0, FB);
      chk("relock_ch", {ch0, ch1, ch2, ch3}, 32'hDEADBEEF);
      c0 = fv_cnt;
      s0 = se_cnt;
      send_frame(32'h11223344, 1'b1, 0, 2 * DW + 3);
      send_frame(32'hC0FFEE77, 1'b1, 0, FB);
      chk("inj_err", 32'(se_cnt - s0), 32'd1);
      chk("inj_one_frame", 32'(fv_cnt - c0), 32'd1);
      chk("inj_ch", {ch0, ch1, ch2, ch3}, 32'hC0FFEE77);
      send_frame(32'h5A5A0F0F, 1'b1, 0, DW + 4);
      c0 = fv_cnt;
      pulse_reset();
      chk("rst_zero", {ch0, ch1, ch2, ch3}, 32'd0);
      send_frame(32'h5A5A0F0F, 1'b0, 0, FB - DW - 4);
      chk("rst_no_frame", 32'(fv_cnt - c0), 32'd0);
      send_frame(32'h87654321, 1'b1, 2, FB);
      chk("rst_new_frame", {ch0, ch1, ch2, ch3}, 32'h87654321);
      for (int k = 0; k < 80; k++) begin
         int r;
         w = $urandom;
         r = $urandom_range(0, 11);
         if (r == 0) send_frame(w, 1'b0, 2, FB);
         else if (r == 1) send_frame(w, 1'b1, 2, $urandom_range(1, FB - 1));
         else if (r == 2) repeat ($urandom_range(1, 6)) step(1'($urandom), 1'($urandom), 1'($urandom));
         else send_frame(w, 1'b1, (r == 3) ? 1 : (r < 7 ? 2 : 0), FB);
         if (k == 40) pulse_reset();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
